z80_bus_responder: RTL and testbench
====================================

# z80_bus_responder

Synthesizable responder for the tv80s Z80-style external bus. It decodes CPU strobes into memory read/write, I/O read/write, interrupt-acknowledge and refresh cycles. It issues exactly one backend access per bus cycle and stretches the cycle with `wait_n` until data is ready. It returns read data on `cpu_di`, replacing behavioural memory/IO models between the `tv80s` core and on-chip synchronous RAM plus an I/O register bank.

## Interface
- `MEM_WAIT`, default 0: extra wait cycles appended to every memory access (0–15).
- `IO_WAIT`, default 1: minimum wait cycles for I/O accesses before `io_ready` is honoured (0–15).
- `IO_TIMEOUT`, default 64: cycles without `io_ready` before an I/O access is force-completed.

Ports:
- `clk` in 1: single clock; CPU and backend share it.
- `reset_n` in 1: asynchronous, active-low reset.
- `A` in 16: CPU address.
- `cpu_dout` in 8: CPU write data.
- `m1_n`, `mreq_n`, `iorq_n`, `rd_n`, `wr_n`, `rfsh_n` in 1 each: CPU strobes.
- `wait_n` out 1: registered; low stretches the CPU cycle.
- `cpu_di` out 8: registered read data to CPU.
- `mem_addr` out 16, `mem_wdata` out 8, `mem_re` out 1, `mem_we` out 1: sync RAM port. `mem_rdata` is valid exactly 1 cycle after `mem_re`.
- `mem_rdata` in 8: RAM read data.
- `io_addr` out 8, `io_wdata` out 8, `io_re` out 1, `io_we` out 1: I/O port with level handshake.
- `io_rdata` in 8, `io_ready` in 1: I/O completion inputs.
- `int_vec` in 8: vector returned on interrupt acknowledge.
- `io_timeout` out 1: sticky; set on any I/O timeout, cleared only by reset.

## Operation
Strobes are sampled on rising `clk`. A cycle starts in `IDLE` only, on the first edge where a qualified strobe is seen. Decode priority:
1. `m1_n=0 & iorq_n=0` -> `INTA`.
2. `mreq_n=0 & rfsh_n=0` -> refresh. Ignored: no backend access, no wait, stay `IDLE`.
3. `mreq_n=0 & rd_n=0` -> `MRD`.
4. `mreq_n=0 & wr_n=0` -> `MWR`.
5. `iorq_n=0 & rd_n=0` -> `IORD`.
6. `iorq_n=0 & wr_n=0` -> `IOWR`.

State behaviour:
- `MRD`: `mem_re` pulses 1 cycle with `mem_addr=A`. Next cycle capture `mem_rdata` into `cpu_di`. Count `MEM_WAIT`, then go to `DONE`.
- `MWR`: `mem_we` pulses 1 cycle with `mem_addr=A`, `mem_wdata=cpu_dout`. Count `MEM_WAIT`, then go to `DONE`.
- `IORD`/`IOWR`: `io_addr=A[7:0]`. Hold `io_re`/`io_we` high until completion. Completion = `io_ready=1` sampled after at least `IO_WAIT` cycles, or the timeout counter reaching `IO_TIMEOUT`.
  - On `io_ready`: `IORD` latches `io_rdata`.
  - On timeout: `IORD` latches `8'hFF`, and `io_timeout` is set.
  - `io_re`/`io_we` drop on the completion edge.
- `INTA`: latch `int_vec` into `cpu_di`, then go to `DONE`. No backend access.
- `DONE`: `wait_n=1`. Stay until `mreq_n`, `iorq_n`, `rd_n` and `wr_n` are all high, then go to `IDLE`. This guarantees one access per bus cycle regardless of CPU stretch.
- Abort: if the qualifying strobe deasserts in any active state:
  - drop all requests the same edge;
  - `wait_n=1`; go to `IDLE`;
  - `cpu_di` keeps its old value;
  - a `mem_we` already pulsed is not undone.
- `cpu_di` holds its last value between cycles. Backend outputs are zero when not requesting.

## Timing
- Reset values: `wait_n=1`, `cpu_di=8'hFF`, `mem_re`/`mem_we`/`io_re`/`io_we=0`, `mem_addr`/`io_addr`/data outputs `=0`, `io_timeout=0`, state `IDLE`.
- Let edge k be the edge where the strobe is detected:
  - `mem_re`/`mem_we` are high during cycle k..k+1.
  - `wait_n` is low from k until the release edge.
  - `MRD` data in `cpu_di` at edge k+2. `wait_n` returns high at edge k+2+`MEM_WAIT`.
  - `MWR`: `wait_n` high at k+1+`MEM_WAIT`.
  - `INTA`: `cpu_di` and `wait_n` high at k+1.
  - I/O: `io_ready` seen at edge j ≥ k+`IO_WAIT` -> data and `wait_n` high at j+1.
- Timeout counter starts at k. Force-complete at edge k+`IO_TIMEOUT`.
- Simultaneous `io_ready` and timeout on the same edge: `io_ready` wins; `io_timeout` is not set.
- Back-to-back cycles: a new strobe is accepted no earlier than 1 edge after `DONE` exits.
- Reset mid-cycle asserts all reset values immediately.

## Test plan
- `MEM_WAIT=2`; RAM[`16'hDCA6`]=`49`; CPU read at `DCA6` -> exactly one `mem_re`, `wait_n` low 4 cycles, `cpu_di=49`.
- CPU write `A=16'h1234`, `cpu_dout=A5` -> single `mem_we` pulse, RAM[`1234`]=`A5`. Strobe held 10 extra cycles produces no second pulse.
- Refresh cycle (`mreq_n=0`, `rfsh_n=0`, `A=007F`) -> no `mem_re`, `wait_n` stays 1, `cpu_di` unchanged.
- I/O read port `3B`, `io_ready` after 5 cycles with `io_rdata=0F` -> `io_re` high 5 cycles, `cpu_di=0F`, `io_timeout=0`. Repeat with `io_ready` never asserted -> completes at 64 cycles, `cpu_di=FF`, `io_timeout=1`.
- `m1_n=0`, `iorq_n=0`, `int_vec=C8` -> no backend access, `cpu_di=C8` one edge after detection.
- `reset_n` low during an I/O wait -> `io_re=0`, `wait_n=1`, `cpu_di=FF` immediately. After release, the next memory read completes normally.

Source files
------------

// File: rtl/z80_bus_responder_if.sv
// CPU-side strobes plus the RAM and I/O backend ports of the Z80 bus responder.
// The responder connects to the slave modport; the bus driver side uses master.
interface z80_bus_responder_if;
    logic [15:0] A;
    logic [7:0]  cpu_dout;
    logic        m1_n;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        rfsh_n;
    logic        wait_n;
    logic [7:0]  cpu_di;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [7:0]  io_addr;
    logic [7:0]  io_wdata;
    logic        io_re;
    logic        io_we;
    logic [7:0]  io_rdata;
    logic        io_ready;
    logic [7:0]  int_vec;
    logic        io_timeout;

    modport slave (
        input  A, cpu_dout, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n,
               mem_rdata, io_rdata, io_ready, int_vec,
        output wait_n, cpu_di, mem_addr, mem_wdata, mem_re, mem_we,
               io_addr, io_wdata, io_re, io_we, io_timeout
    );

    modport master (
        output A, cpu_dout, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n,
               mem_rdata, io_rdata, io_ready, int_vec,
        input  wait_n, cpu_di, mem_addr, mem_wdata, mem_re, mem_we,
               io_addr, io_wdata, io_re, io_we, io_timeout
    );
endinterface

// File: rtl/z80_bus_responder.sv
// Decodes tv80s bus strobes into single RAM / I/O / interrupt-acknowledge accesses,
// stretching the CPU cycle with wait_n until read data is in cpu_di.
module z80_bus_responder #(
    parameter int MEM_WAIT   = 0,
    parameter int IO_WAIT    = 1,
    parameter int IO_TIMEOUT = 64
) (
    input logic                clk,
    input logic                reset_n,
    z80_bus_responder_if.slave bus
);
    // cnt holds (edges since detection - 1) while a cycle is active
    localparam logic [15:0] MEM_RD_LAST = 16'(MEM_WAIT + 1);
    localparam logic [15:0] MEM_WR_LAST = 16'(MEM_WAIT);
    localparam logic [15:0] IO_MIN      = 16'(IO_WAIT);
    localparam logic [15:0] IO_LAST     = 16'((IO_TIMEOUT > 1) ? IO_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {IDLE, MRD, MWR, IORD, IOWR, INTA, DONE} state_t;

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic        wait_q, wait_nx;
    logic [7:0]  di_q, di_nx;
    logic        mem_re_q, mem_re_nx, mem_we_q, mem_we_nx;
    logic [15:0] mem_addr_q, mem_addr_nx;
    logic [7:0]  mem_wdata_q, mem_wdata_nx;
    logic        io_re_q, io_re_nx, io_we_q, io_we_nx;
    logic [7:0]  io_addr_q, io_addr_nx, io_wdata_q, io_wdata_nx;
    logic        tmo_q, tmo_nx;
    logic        qual, ready_ok, tmo_hit, bus_idle;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            wait_q      <= 1'b1;
            di_q        <= 8'hFF;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            io_re_q     <= 1'b0;
            io_we_q     <= 1'b0;
            io_addr_q   <= '0;
            io_wdata_q  <= '0;
            tmo_q       <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            wait_q      <= wait_nx;
            di_q        <= di_nx;
            mem_re_q    <= mem_re_nx;
            mem_we_q    <= mem_we_nx;
            mem_addr_q  <= mem_addr_nx;
            mem_wdata_q <= mem_wdata_nx;
            io_re_q     <= io_re_nx;
            io_we_q     <= io_we_nx;
            io_addr_q   <= io_addr_nx;
            io_wdata_q  <= io_wdata_nx;
            tmo_q       <= tmo_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        wait_nx      = wait_q;
        di_nx        = di_q;
        mem_re_nx    = 1'b0;
        mem_we_nx    = 1'b0;
        mem_addr_nx  = '0;
        mem_wdata_nx = '0;
        io_re_nx     = io_re_q;
        io_we_nx     = io_we_q;
        io_addr_nx   = io_addr_q;
        io_wdata_nx  = io_wdata_q;
        tmo_nx       = tmo_q;
        ready_ok     = bus.io_ready && (cnt >= IO_MIN);
        tmo_hit      = (cnt >= IO_LAST);
        bus_idle     = bus.mreq_n && bus.iorq_n && bus.rd_n && bus.wr_n;

        case (state)
            MRD:     qual = !bus.mreq_n && !bus.rd_n;
            MWR:     qual = !bus.mreq_n && !bus.wr_n;
            IORD:    qual = !bus.iorq_n && !bus.rd_n;
            IOWR:    qual = !bus.iorq_n && !bus.wr_n;
            INTA:    qual = !bus.m1_n && !bus.iorq_n;
            default: qual = 1'b0;
        endcase

        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (!bus.m1_n && !bus.iorq_n) begin
                    state_nx = INTA;
                    wait_nx  = 1'b0;
                end else if (!bus.mreq_n && !bus.rfsh_n) begin
                    state_nx = IDLE;
                end else if (!bus.mreq_n && !bus.rd_n) begin
                    state_nx    = MRD;
                    wait_nx     = 1'b0;
                    mem_re_nx   = 1'b1;
                    mem_addr_nx = bus.A;
                end else if (!bus.mreq_n && !bus.wr_n) begin
                    state_nx     = MWR;
                    wait_nx      = 1'b0;
                    mem_we_nx    = 1'b1;
                    mem_addr_nx  = bus.A;
                    mem_wdata_nx = bus.cpu_dout;
                end else if (!bus.iorq_n && !bus.rd_n) begin
                    state_nx   = IORD;
                    wait_nx    = 1'b0;
                    io_re_nx   = 1'b1;
                    io_addr_nx = bus.A[7:0];
                end else if (!bus.iorq_n && !bus.wr_n) begin
                    state_nx    = IOWR;
                    wait_nx     = 1'b0;
                    io_we_nx    = 1'b1;
                    io_addr_nx  = bus.A[7:0];
                    io_wdata_nx = bus.cpu_dout;
                end
            end
            // Held here until the CPU ends its cycle, so a stretched strobe never re-triggers
            DONE: begin
                if (bus_idle) state_nx = IDLE;
            end
            default: begin
                cnt_nx = cnt + 16'd1;
                if (!qual) begin
                    state_nx    = IDLE;
                    wait_nx     = 1'b1;
                    io_re_nx    = 1'b0;
                    io_we_nx    = 1'b0;
                    io_addr_nx  = '0;
                    io_wdata_nx = '0;
                end else begin
                    case (state)
                        MRD: begin
                            if (cnt == 16'd1) di_nx = bus.mem_rdata;
                            if (cnt == MEM_RD_LAST) begin
                                state_nx = DONE;
                                wait_nx  = 1'b1;
                            end
                        end
                        MWR: begin
                            if (cnt == MEM_WR_LAST) begin
                                state_nx = DONE;
                                wait_nx  = 1'b1;
                            end
                        end
                        INTA: begin
                            di_nx    = bus.int_vec;
                            state_nx = DONE;
                            wait_nx  = 1'b1;
                        end
                        default: begin
                            // io_ready takes precedence over a timeout landing on the same edge
                            if (ready_ok || tmo_hit) begin
                                if (state == IORD) di_nx = ready_ok ? bus.io_rdata : 8'hFF;
                                if (!ready_ok) tmo_nx = 1'b1;
                                state_nx    = DONE;
                                wait_nx     = 1'b1;
                                io_re_nx    = 1'b0;
                                io_we_nx    = 1'b0;
                                io_addr_nx  = '0;
                                io_wdata_nx = '0;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    assign bus.wait_n     = wait_q;
    assign bus.cpu_di     = di_q;
    assign bus.mem_re     = mem_re_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.io_re      = io_re_q;
    assign bus.io_we      = io_we_q;
    assign bus.io_addr    = io_addr_q;
    assign bus.io_wdata   = io_wdata_q;
    assign bus.io_timeout = tmo_q;
endmodule

// File: tb/tb_z80_bus_responder.sv
// Bench for z80_bus_responder: directed bus cycles plus random traffic, checked every
// cycle against expectations derived from the bus timing rules.
module tb_z80_bus_responder;
    localparam int MW = 2;
    localparam int IW = 1;
    localparam int IT = 64;
    localparam int K_MRD = 0, K_MWR = 1, K_IORD = 2, K_IOWR = 3, K_INTA = 4, K_RFSH = 5;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    z80_bus_responder_if bus ();

    z80_bus_responder #(.MEM_WAIT(MW), .IO_WAIT(IW), .IO_TIMEOUT(IT)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Synchronous RAM backend: read data valid the cycle after mem_re
    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
    end

    int n_checks, n_errors;
    int n_wait_low, n_mem_re, n_mem_we, n_io_req;
    logic chk_en;
    logic exp_wait_n, exp_mem_re, exp_mem_we, exp_io_re, exp_io_we, exp_timeout;
    logic [7:0]  mdl_cpu_di;
    logic [15:0] cur_a;
    logic [7:0]  cur_dout;
    logic [7:0]  ref_mem [logic [15:0]];
    logic [15:0] written [$];

    function automatic void chk(string name, int act, int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wait_n", int'(bus.wait_n), int'(exp_wait_n));
            chk("cpu_di", int'(bus.cpu_di), int'(mdl_cpu_di));
            chk("mem_re", int'(bus.mem_re), int'(exp_mem_re));
            chk("mem_we", int'(bus.mem_we), int'(exp_mem_we));
            chk("io_re", int'(bus.io_re), int'(exp_io_re));
            chk("io_we", int'(bus.io_we), int'(exp_io_we));
            chk("io_timeout", int'(bus.io_timeout), int'(exp_timeout));
            chk("mem_addr", int'(bus.mem_addr), (exp_mem_re || exp_mem_we) ? int'(cur_a) : 0);
            if (exp_mem_we || !exp_mem_re)
                chk("mem_wdata", int'(bus.mem_wdata), exp_mem_we ? int'(cur_dout) : 0);
            chk("io_addr", int'(bus.io_addr), (exp_io_re || exp_io_we) ? int'(cur_a[7:0]) : 0);
            if (exp_io_we || !exp_io_re)
                chk("io_wdata", int'(bus.io_wdata), exp_io_we ? int'(cur_dout) : 0);
        end
        if (!bus.wait_n) n_wait_low++;
        if (bus.mem_re) n_mem_re++;
        if (bus.mem_we) n_mem_we++;
        if (bus.io_re || bus.io_we) n_io_req++;
    end

    task automatic release_strobes();
        bus.m1_n = 1'b1; bus.mreq_n = 1'b1; bus.iorq_n = 1'b1;
        bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.rfsh_n = 1'b1;
    endtask

    // One CPU bus cycle. Called just after a rising edge; returns just after the edge
    // where the responder is back in idle. dly: edge (after detection) where io_ready is
    // first sampled high, 0 = never. abort_at: edge where the strobe is already gone.
    task automatic run_txn(input int kind, input logic [15:0] addr, input logic [7:0] dout,
                           input int dly, input int hold, input int abort_at);
        int r, last, data_edge, rr;
        bit tmo, active, is_io, has_data;
        logic [7:0] newdi;
        cur_a = addr; cur_dout = dout;
        bus.A = addr; bus.cpu_dout = dout;
        newdi = mdl_cpu_di; tmo = 1'b0; r = 0;
        is_io = (kind == K_IORD) || (kind == K_IOWR);
        has_data = (kind == K_MRD) || (kind == K_INTA) || (kind == K_IORD);
        release_strobes();
        case (kind)
            K_MRD: begin
                r = 2 + MW; newdi = ref_mem[addr];
                bus.mreq_n = 1'b0; bus.rd_n = 1'b0; bus.m1_n = 1'($urandom_range(0, 1));
            end
            K_MWR: begin
                r = 1 + MW; ref_mem[addr] = dout; written.push_back(addr);
                bus.mreq_n = 1'b0; bus.wr_n = 1'b0;
            end
            K_INTA: begin
                r = 1; newdi = bus.int_vec;
                bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
            end
            K_RFSH: begin
                r = 0;
                bus.mreq_n = 1'b0; bus.rfsh_n = 1'b0;
            end
            default: begin
                rr = (dly > IW + 1) ? dly : IW + 1;
                tmo = (dly == 0) || (rr > IT);
                r = tmo ? IT : rr;
                if (kind == K_IORD) newdi = tmo ? 8'hFF : bus.io_rdata;
                bus.iorq_n = 1'b0;
                if (kind == K_IORD) bus.rd_n = 1'b0; else bus.wr_n = 1'b0;
            end
        endcase
        data_edge = (kind == K_MRD) ? 2 : r;
        last = (abort_at > 0) ? abort_at : r + hold + 1;
        for (int n = 0; n <= last; n++) begin
            @(posedge clk); #1;
            active = (abort_at > 0) ? (n < abort_at) : (n < r);
            exp_wait_n = !active;
            exp_mem_re = (kind == K_MRD) && (n == 0);
            exp_mem_we = (kind == K_MWR) && (n == 0);
            exp_io_re  = (kind == K_IORD) && active;
            exp_io_we  = (kind == K_IOWR) && active;
            if (abort_at == 0 && has_data && n == data_edge) mdl_cpu_di = newdi;
            if (abort_at == 0 && is_io && tmo && n == r) exp_timeout = 1'b1;
            bus.io_ready = is_io && dly > 0 && abort_at == 0 && (n + 1 >= dly) && (n < r);
            if (n == last - 1) release_strobes();
        end
    endtask

    task automatic run_random(input int count);
        int kind, dly, hold, abort_at;
        logic [15:0] addr;
        logic [7:0] dout;
        for (int t = 0; t < count; t++) begin
            kind = int'($urandom_range(0, 5));
            addr = 16'($urandom);
            dout = 8'($urandom);
            dly = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
            hold = int'($urandom_range(0, 3));
            abort_at = 0;
            if (kind == K_MRD) addr = written[$urandom_range(0, written.size() - 1)];
            if ((kind == K_MRD || kind == K_IORD || kind == K_IOWR) && $urandom_range(0, 7) == 0)
                abort_at = 1;
            bus.io_rdata = 8'($urandom);
            bus.int_vec = 8'($urandom);
            run_txn(kind, addr, dout, dly, hold, abort_at);
        end
    endtask

    int s_wait, s_re, s_we, s_io;
    task automatic snap();
        s_wait = n_wait_low; s_re = n_mem_re; s_we = n_mem_we; s_io = n_io_req;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; chk_en = 1'b0;
        n_wait_low = 0; n_mem_re = 0; n_mem_we = 0; n_io_req = 0;
        exp_wait_n = 1'b1; exp_mem_re = 1'b0; exp_mem_we = 1'b0;
        exp_io_re = 1'b0; exp_io_we = 1'b0; exp_timeout = 1'b0;
        mdl_cpu_di = 8'hFF; cur_a = '0; cur_dout = '0;
        bus.A = '0; bus.cpu_dout = '0; bus.io_ready = 1'b0; bus.io_rdata = '0; bus.int_vec = '0;
        release_strobes();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wait_n", int'(bus.wait_n), 1);
        chk("rst_cpu_di", int'(bus.cpu_di), 'hFF);
        chk("rst_mem_re", int'(bus.mem_re), 0);
        chk("rst_io_re", int'(bus.io_re), 0);
        chk("rst_io_timeout", int'(bus.io_timeout), 0);
        chk("rst_mem_addr", int'(bus.mem_addr), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        snap();
        run_txn(K_MWR, 16'h1234, 8'hA5, 0, 10, 0);
        chk("wr_pulse_count", n_mem_we - s_we, 1);
        chk("ram_1234", int'(ram[16'h1234]), 'hA5);
        run_txn(K_MWR, 16'hDCA6, 8'h49, 0, 0, 0);

        snap();
        run_txn(K_MRD, 16'hDCA6, 8'h00, 0, 2, 0);
        chk("rd_cpu_di", int'(bus.cpu_di), 'h49);
        chk("rd_re_count", n_mem_re - s_re, 1);
        chk("rd_wait_cycles", n_wait_low - s_wait, 4);

        snap();
        run_txn(K_RFSH, 16'h007F, 8'h00, 0, 3, 0);
        chk("rfsh_re_count", n_mem_re - s_re, 0);
        chk("rfsh_wait_cycles", n_wait_low - s_wait, 0);
        chk("rfsh_cpu_di", int'(bus.cpu_di), 'h49);

        bus.io_rdata = 8'h0F;
        snap();
        run_txn(K_IORD, 16'h003B, 8'h00, 5, 1, 0);
        chk("iord_req_cycles", n_io_req - s_io, 5);
        chk("iord_cpu_di", int'(bus.cpu_di), 'h0F);
        chk("iord_timeout", int'(bus.io_timeout), 0);

        snap();
        run_txn(K_IORD, 16'h003B, 8'h00, 0, 0, 0);
        chk("tmo_req_cycles", n_io_req - s_io, 64);
        chk("tmo_cpu_di", int'(bus.cpu_di), 'hFF);
        chk("tmo_flag", int'(bus.io_timeout), 1);

        bus.int_vec = 8'hC8;
        snap();
        run_txn(K_INTA, 16'h0000, 8'h00, 0, 1, 0);
        chk("inta_cpu_di", int'(bus.cpu_di), 'hC8);
        chk("inta_backend", (n_mem_re - s_re) + (n_mem_we - s_we) + (n_io_req - s_io), 0);

        snap();
        run_txn(K_IORD, 16'h0055, 8'h00, 0, 0, 3);
        chk("abort_req_cycles", n_io_req - s_io, 3);
        chk("abort_cpu_di", int'(bus.cpu_di), 'hC8);

        // Reset in the middle of an I/O wait
        chk_en = 1'b0;
        bus.A = 16'h0042; bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_io_re", int'(bus.io_re), 0);
        chk("mid_rst_wait_n", int'(bus.wait_n), 1);
        chk("mid_rst_cpu_di", int'(bus.cpu_di), 'hFF);
        chk("mid_rst_timeout", int'(bus.io_timeout), 0);
        release_strobes();
        @(posedge clk); #1;
        reset_n = 1'b1;
        mdl_cpu_di = 8'hFF; exp_timeout = 1'b0;
        exp_wait_n = 1'b1; exp_mem_re = 1'b0; exp_mem_we = 1'b0;
        exp_io_re = 1'b0; exp_io_we = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;

        run_txn(K_MRD, 16'hDCA6, 8'h00, 0, 0, 0);
        chk("post_rst_rd", int'(bus.cpu_di), 'h49);

        run_random(60);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
